// File: rtl/axis_frame_sink_if.sv
// AXI-Stream beat channel carrying packed 24-bit pixels (pixel p in bits [24p+23:24p]).
interface axis_frame_sink_if #(
    parameter int DATA_WIDTH = 96
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: unpacks keep-masked beats into single pixels with (x, y)
// coordinates, checks row lengths against ROW_PIXELS and runs exactly one frame per start.
module axis_frame_sink #(
    parameter int  AXIS_DATA_WIDTH = 96,
    parameter int  ROW_PIXELS      = 4096,
    parameter int  ROW_COUNT       = 2160,
    localparam int XW              = $clog2(ROW_PIXELS),
    localparam int YW              = $clog2(ROW_COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    axis_frame_sink_if.slave s_axis,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [23:0]      pix_data,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             busy,
    output logic             frame_done,
    output logic             err_keep,
    output logic             err_row_len
);
    localparam int PPB = AXIS_DATA_WIDTH / 24;
    localparam int CW  = XW + 1;
    localparam logic [CW-1:0] ROW_LEN = CW'(ROW_PIXELS);
    localparam logic [XW-1:0] X_MAX   = XW'(ROW_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(ROW_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       held_q, held_d;
    logic [PPB-1:0]             mask_q, mask_d;
    logic                       last_q, last_d;
    logic [AXIS_DATA_WIDTH-1:0] data_q;
    // Row pixel count; one bit wider than pix_x so overlong rows stay visible.
    logic [CW-1:0]              cnt_q, cnt_d, cnt_next;
    logic [YW-1:0]              y_q, y_d;
    logic                       err_keep_q, err_keep_d;
    logic                       err_row_q, err_row_d;

    logic [PPB-1:0] in_mask;
    logic           in_mixed;
    logic [PPB-1:0] mask_rest;
    logic [23:0]    sel_data;
    logic           pix_hs;
    logic           retire;
    logic           row_end;
    logic           frame_end;
    logic           tready;
    logic           accept;

    // Incoming beat: a pixel is valid only when all three of its keep bits are set.
    always_comb begin
        in_mask  = '0;
        in_mixed = 1'b0;
        for (int p = 0; p < PPB; p++) begin
            in_mask[p] = &s_axis.tkeep[3*p +: 3];
            if ((|s_axis.tkeep[3*p +: 3]) && !(&s_axis.tkeep[3*p +: 3])) begin
                in_mixed = 1'b1;
            end
        end
    end

    // Lowest remaining mask bit is the next pixel in raster order.
    always_comb begin
        sel_data = '0;
        for (int p = PPB - 1; p >= 0; p--) begin
            if (mask_q[p]) begin
                sel_data = data_q[24*p +: 24];
            end
        end
    end

    assign mask_rest = mask_q & (mask_q - PPB'(1));
    assign pix_valid = held_q & (|mask_q);
    assign pix_hs    = pix_valid & pix_ready;
    assign retire    = held_q & (~(|mask_q) | (pix_hs & ~(|mask_rest)));
    assign row_end   = retire & last_q;
    assign frame_end = row_end & (y_q == Y_LAST);
    // The final retiring beat of a frame must not let a new beat in behind it.
    assign tready    = (state_q == S_RUN) & (~held_q | (retire & ~frame_end));
    assign accept    = s_axis.tvalid & tready;

    assign s_axis.tready = tready;
    assign pix_data      = pix_valid ? sel_data : 24'd0;
    assign pix_x         = (cnt_q >= ROW_LEN) ? X_MAX : cnt_q[XW-1:0];
    assign pix_y         = y_q;
    assign busy          = (state_q == S_RUN);
    assign frame_done    = (state_q == S_DONE);
    assign err_keep      = err_keep_q;
    assign err_row_len   = err_row_q;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        held_d     = held_q;
        mask_d     = mask_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        cnt_next   = cnt_q;
        y_d        = y_q;
        err_keep_d = err_keep_q;
        err_row_d  = err_row_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    held_d     = 1'b0;
                    mask_d     = '0;
                    last_d     = 1'b0;
                    cnt_d      = '0;
                    y_d        = '0;
                    err_keep_d = 1'b0;
                    err_row_d  = 1'b0;
                end
            end

            S_RUN: begin
                if (pix_hs) begin
                    if (cnt_q >= ROW_LEN) begin
                        err_row_d = 1'b1;
                    end
                    // Saturate at ROW_LEN+1: enough to flag an overlong row.
                    if (cnt_q <= ROW_LEN) begin
                        cnt_next = cnt_q + CW'(1);
                    end
                    mask_d = mask_rest;
                end
                cnt_d = cnt_next;

                if (retire) begin
                    held_d = 1'b0;
                    if (last_q) begin
                        if (cnt_next != ROW_LEN) begin
                            err_row_d = 1'b1;
                        end
                        cnt_d = '0;
                        y_d   = frame_end ? '0 : y_q + YW'(1);
                    end
                end

                if (accept) begin
                    held_d = 1'b1;
                    mask_d = in_mask;
                    last_d = s_axis.tlast;
                    if (in_mixed) begin
                        err_keep_d = 1'b1;
                    end
                end

                if (frame_end) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            held_q     <= 1'b0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            y_q        <= '0;
            err_keep_q <= 1'b0;
            err_row_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            err_keep_q <= err_keep_d;
            err_row_q  <= err_row_d;
        end
    end

    // NOTE: the beat payload has no reset; it is only observed through pix_data, which is zero unless pix_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= s_axis.tdata;
        end
    end
endmodule

// File: tb/tb_axis_frame_sink.sv
// Directed bench for axis_frame_sink: instance a has 8-pixel rows, instance b 6-pixel rows,
// both two rows per frame; one shared beat driver and pixel monitor follow the 'sel' instance.
module tb_axis_frame_sink;
    typedef struct packed {
        logic [95:0] d;
        logic [11:0] k;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  x;
        logic        y;
    } pix_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_a    = 1'b0;
    logic        start_b    = 1'b0;
    logic        sel        = 1'b0;
    logic        tvalid     = 1'b0;
    logic [95:0] tdata      = '0;
    logic [11:0] tkeep      = '0;
    logic        tlast      = 1'b0;
    logic        pix_ready  = 1'b1;
    logic        rand_ready = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    axis_frame_sink_if #(.DATA_WIDTH(96)) ax_a ();
    axis_frame_sink_if #(.DATA_WIDTH(96)) ax_b ();

    assign ax_a.tvalid = tvalid & ~sel;
    assign ax_a.tdata  = tdata;
    assign ax_a.tkeep  = tkeep;
    assign ax_a.tlast  = tlast;
    assign ax_b.tvalid = tvalid & sel;
    assign ax_b.tdata  = tdata;
    assign ax_b.tkeep  = tkeep;
    assign ax_b.tlast  = tlast;

    logic        pv_a, busy_a, done_a, ek_a, er_a, py_a;
    logic [23:0] pd_a;
    logic [2:0]  px_a;
    logic        pv_b, busy_b, done_b, ek_b, er_b, py_b;
    logic [23:0] pd_b;
    logic [2:0]  px_b;

    axis_frame_sink #(.AXIS_DATA_WIDTH(96), .ROW_PIXELS(8), .ROW_COUNT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .s_axis(ax_a),
        .pix_valid(pv_a), .pix_ready(pix_ready), .pix_data(pd_a), .pix_x(px_a), .pix_y(py_a),
        .busy(busy_a), .frame_done(done_a), .err_keep(ek_a), .err_row_len(er_a)
    );

    axis_frame_sink #(.AXIS_DATA_WIDTH(96), .ROW_PIXELS(6), .ROW_COUNT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .s_axis(ax_b),
        .pix_valid(pv_b), .pix_ready(pix_ready), .pix_data(pd_b), .pix_x(px_b), .pix_y(py_b),
        .busy(busy_b), .frame_done(done_b), .err_keep(ek_b), .err_row_len(er_b)
    );

    logic        tready_m, pv, busy_m, done_m, ek_m, er_m, py;
    logic [23:0] pd;
    logic [2:0]  px;
    assign tready_m = sel ? ax_b.tready : ax_a.tready;
    assign pv       = sel ? pv_b : pv_a;
    assign pd       = sel ? pd_b : pd_a;
    assign px       = sel ? px_b : px_a;
    assign py       = sel ? py_b : py_a;
    assign busy_m   = sel ? busy_b : busy_a;
    assign done_m   = sel ? done_b : done_a;
    assign ek_m     = sel ? ek_b : ek_a;
    assign er_m     = sel ? er_b : er_a;

    beat_t beat_q[$];
    pix_t  cap_q[$];
    pix_t  exp_q[$];
    int    cyc = 0, done_cnt = 0, done_cyc = 0, last_pix_cyc = 0, stall_viol = 0;
    logic  prev_stall = 1'b0;
    pix_t  prev_pix = '0;

    // Beat driver: presents the queue head, pops it after an observed handshake.
    initial begin : driver
        logic take;
        forever begin
            @(negedge clk);
            take = tvalid && tready_m;
            @(posedge clk);
            #1;
            if (take && beat_q.size() > 0) void'(beat_q.pop_front());
            if (beat_q.size() > 0) begin
                tvalid = 1'b1;
                tdata  = beat_q[0].d;
                tkeep  = beat_q[0].k;
                tlast  = beat_q[0].l;
            end else begin
                tvalid = 1'b0;
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
        end
    end

    // Pixel monitor: captures handshakes and counts stall-stability / tready-during-stall violations.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (pv !== 1'b1 || {pd, px, py} !== prev_pix)) stall_viol++;
                if (pv && !pix_ready && tready_m) stall_viol++;
                if (pv && pix_ready) begin
                    cap_q.push_back({pd, px, py});
                    last_pix_cyc = cyc;
                end
                if (done_m) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = pv && !pix_ready;
                prev_pix   = {pd, px, py};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pv_of(input int f, input int y, input int i);
        return 24'((f << 16) | (y << 8) | i);
    endfunction

    function automatic beat_t mk(input int f, input int y, input int i0, input logic [11:0] k, input logic l);
        beat_t b;
        b = '0;
        for (int p = 0; p < 4; p++) b.d[24*p +: 24] = pv_of(f, y, i0 + p);
        b.k = k;
        b.l = l;
        return b;
    endfunction

    function automatic pix_t ex(input int f, input int y, input int i, input int x);
        pix_t e;
        e.d = pv_of(f, y, i);
        e.x = 3'(x);
        e.y = 1'(y);
        return e;
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        rand_ready = 1'b0;
        pix_ready  = 1'b1;
        beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cap_q.delete();
        exp_q.delete();
        done_cnt   = 0;
        stall_viol = 0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400 && done_cnt == 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tready_m !== 1'b0) $display("FAIL reset_tready: got %b want 0", tready_m);
        else passed++;
        checks++;
        if ({pv, busy_m, done_m, ek_m, er_m} !== 5'b0)
            $display("FAIL reset_flags: got valid/busy/done/ek/er=%b want 00000", {pv, busy_m, done_m, ek_m, er_m});
        else passed++;
        checks++;
        if ({pd, px, py} !== 28'd0) $display("FAIL reset_pixel: got d=%h x=%0d y=%0d want 0/0/0", pd, px, py);
        else passed++;
        checks++;
        if ({ax_b.tready, pv_b, busy_b, done_b, ek_b, er_b, pd_b, px_b, py_b} !== 34'd0)
            $display("FAIL reset_dut_b: outputs not all zero");
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_no_start();
        sel = 1'b0;
        apply_reset();
        beat_q.push_back(mk(9, 0, 0, 12'hFFF, 1'b1));
        repeat (6) @(negedge clk);
        checks++;
        if (beat_q.size() != 1 || cap_q.size() != 0)
            $display("FAIL no_start_accept: got queue=%0d pixels=%0d want 1/0", beat_q.size(), cap_q.size());
        else passed++;
        checks++;
        if (tready_m !== 1'b0 || busy_m !== 1'b0) $display("FAIL no_start_idle: got tready=%b busy=%b want 0/0", tready_m, busy_m);
        else passed++;
    endtask

    task automatic test_basic_frame();
        sel = 1'b0;
        apply_reset();
        for (int y = 0; y < 2; y++) begin
            beat_q.push_back(mk(1, y, 0, 12'hFFF, 1'b0));
            beat_q.push_back(mk(1, y, 4, 12'hFFF, 1'b1));
            for (int i = 0; i < 8; i++) exp_q.push_back(ex(1, y, i, i));
        end
        do_start();
        @(negedge clk);
        checks++;
        if (busy_m !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_m);
        else passed++;
        wait_done();
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL basic_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        checks++;
        if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt);
        else passed++;
        checks++;
        if (done_cyc != last_pix_cyc + 1) $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, last_pix_cyc + 1);
        else passed++;
        checks++;
        if ({ek_m, er_m} !== 2'b00 || busy_m !== 1'b0)
            $display("FAIL basic_end_flags: got ek=%b er=%b busy=%b want 0/0/0", ek_m, er_m, busy_m);
        else passed++;
    endtask

    task automatic test_keep_drop();
        sel = 1'b1;
        apply_reset();
        for (int y = 0; y < 2; y++) begin
            beat_q.push_back(mk(2, y, 0, 12'hFC0, 1'b0));
            beat_q.push_back(mk(2, y, 4, 12'hFFF, 1'b1));
            for (int i = 2; i < 8; i++) exp_q.push_back(ex(2, y, i, i - 2));
        end
        do_start();
        wait_done();
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL keep_drop_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL keep_drop_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        checks++;
        if ({ek_m, er_m} !== 2'b00 || done_cnt != 1)
            $display("FAIL keep_drop_flags: got ek=%b er=%b done=%0d want 0/0/1", ek_m, er_m, done_cnt);
        else passed++;
        sel = 1'b0;
    endtask

    task automatic test_stall();
        sel = 1'b0;
        apply_reset();
        for (int y = 0; y < 2; y++) begin
            beat_q.push_back(mk(3, y, 0, 12'hFFF, 1'b0));
            beat_q.push_back(mk(3, y, 4, 12'hFFF, 1'b1));
            for (int i = 0; i < 8; i++) exp_q.push_back(ex(3, y, i, i));
        end
        rand_ready = 1'b1;
        do_start();
        wait_done();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        checks++;
        if (stall_viol != 0) $display("FAIL stall_stability: got %0d violations want 0", stall_viol);
        else passed++;
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL stall_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        checks++;
        if (done_cnt != 1 || {ek_m, er_m} !== 2'b00)
            $display("FAIL stall_end: got done=%0d ek=%b er=%b want 1/0/0", done_cnt, ek_m, er_m);
        else passed++;
    endtask

    task automatic test_mixed_keep();
        sel = 1'b0;
        apply_reset();
        beat_q.push_back(mk(4, 0, 8, 12'h0F0, 1'b0));
        beat_q.push_back(mk(4, 0, 0, 12'hFFF, 1'b0));
        beat_q.push_back(mk(4, 0, 4, 12'hFFF, 1'b1));
        beat_q.push_back(mk(4, 1, 0, 12'hFFF, 1'b0));
        beat_q.push_back(mk(4, 1, 4, 12'hFFF, 1'b1));
        for (int y = 0; y < 2; y++)
            for (int i = 0; i < 8; i++) exp_q.push_back(ex(4, y, i, i));
        do_start();
        wait_done();
        checks++;
        if (ek_m !== 1'b1 || er_m !== 1'b0) $display("FAIL mixed_keep_flags: got ek=%b er=%b want 1/0", ek_m, er_m);
        else passed++;
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL mixed_keep_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL mixed_keep_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        do_start();
        @(negedge clk);
        checks++;
        if (ek_m !== 1'b0) $display("FAIL mixed_keep_clear: got ek=%b want 0", ek_m);
        else passed++;
    endtask

    task automatic test_row_len();
        sel = 1'b0;
        apply_reset();
        beat_q.push_back(mk(5, 0, 0, 12'hFFF, 1'b0));
        beat_q.push_back(mk(5, 0, 4, 12'h1FF, 1'b1));
        for (int i = 0; i < 7; i++) exp_q.push_back(ex(5, 0, i, i));
        do_start();
        for (int n = 0; n < 100 && cap_q.size() < 7; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (er_m !== 1'b1 || done_cnt != 0) $display("FAIL row_short: got er=%b done=%0d want 1/0", er_m, done_cnt);
        else passed++;
        beat_q.push_back(mk(5, 1, 0, 12'hFFF, 1'b0));
        beat_q.push_back(mk(5, 1, 4, 12'hFFF, 1'b0));
        beat_q.push_back(mk(5, 1, 8, 12'h007, 1'b1));
        for (int i = 0; i < 9; i++) exp_q.push_back(ex(5, 1, i, (i > 7) ? 7 : i));
        wait_done();
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL row_len_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL row_len_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        checks++;
        if (done_cnt != 1 || er_m !== 1'b1) $display("FAIL row_len_end: got done=%0d er=%b want 1/1", done_cnt, er_m);
        else passed++;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        apply_reset();
        pix_ready = 1'b0;
        beat_q.push_back(mk(6, 0, 0, 12'hFFF, 1'b0));
        beat_q.push_back(mk(6, 0, 4, 12'hFFF, 1'b0));
        do_start();
        repeat (5) @(negedge clk);
        checks++;
        if (pv !== 1'b1 || pd !== pv_of(6, 0, 0) || px !== 3'd0)
            $display("FAIL reset_mid_held: got valid=%b d=%h x=%0d want 1/%h/0", pv, pd, px, pv_of(6, 0, 0));
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({tready_m, pv, busy_m, done_m, ek_m, er_m} !== 6'b0 || {pd, px, py} !== 28'd0)
            $display("FAIL reset_mid_outputs: got tready/valid/busy=%b%b%b d=%h x=%0d y=%0d want all zero",
                     tready_m, pv, busy_m, pd, px, py);
        else passed++;
        beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pix_ready = 1'b1;
        @(posedge clk);
        #1;
        cap_q.delete();
        exp_q.delete();
        done_cnt = 0;
        for (int y = 0; y < 2; y++) begin
            beat_q.push_back(mk(7, y, 0, 12'hFFF, 1'b0));
            beat_q.push_back(mk(7, y, 4, 12'hFFF, 1'b1));
            for (int i = 0; i < 8; i++) exp_q.push_back(ex(7, y, i, i));
        end
        do_start();
        wait_done();
        checks++;
        if (cap_q.size() != exp_q.size()) $display("FAIL reset_mid_count: got %0d want %0d", cap_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            pix_t got;
            got = (i < cap_q.size()) ? cap_q[i] : '1;
            checks++;
            if (got !== exp_q[i])
                $display("FAIL reset_mid_pix%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                         i, got.d, got.x, got.y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
            else passed++;
        end
        checks++;
        if (done_cnt != 1) $display("FAIL reset_mid_done: got %0d want 1", done_cnt);
        else passed++;
    endtask

    initial begin : main
        test_reset();
        test_no_start();
        test_basic_frame();
        test_keep_drop();
        test_stall();
        test_mixed_keep();
        test_row_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
